// File: rtl/ps2_key_pkg.sv
// Shared types and constants for the PS/2 keyboard decoder.
// The optional odd-parity check is enabled with PS2_KEY_PARITY_CHECK_EN.
package ps2_key_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam int KEY_EXT     = 8;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_TOGGLE  = 10;

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser plus FILTER_LEN-deep agreement filter for one PS/2 line.
// Emits the filtered level and a one-cycle pulse on each filtered 1->0 edge.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] shift_q;
  logic                  level_q;
  logic                  fall_q;

  // NOTE: idle PS/2 lines float high, so every stage resets to 1; a reset
  // value of 0 would look like a falling clock edge right after reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '1;
      shift_q <= '1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], line_i};
      shift_q <= {shift_q[FILTER_LEN-2:0], sync_q[1]};
      fall_q  <= 1'b0;
      // The level moves only once the whole window agrees.
      if (&shift_q) begin
        level_q <= 1'b1;
      end else if (~|shift_q) begin
        level_q <= 1'b0;
        fall_q  <= level_q;
      end
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 device-to-host frame receiver and make/break decoder producing ps2_key.
// Define PS2_KEY_PARITY_CHECK_EN to reject frames with a bad odd-parity bit.
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 24000,
  parameter int FILTER_LEN     = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic clk_level;
  logic clk_fall;
  logic bit_evt;
  logic data_s;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .line_i  (ps2_clk_in),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  logic [1:0] data_sync_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      data_sync_q <= '1;
    end else begin
      data_sync_q <= {data_sync_q[0], ps2_data_in};
    end
  end

  assign data_s  = data_sync_q[1];
  // The fall pulse always coincides with a low filtered level.
  assign bit_evt = clk_fall && !clk_level;

  ps2_state_e    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    count_q, count_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [10:0]   key_q, key_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          stop_bad;

`ifdef PS2_KEY_PARITY_CHECK_EN
  logic parity_q, parity_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_d = (bit_evt && state_q == S_PARITY) ? data_s : parity_q;
  assign stop_bad = !data_s || !(^{shift_q, parity_q});
`else
  assign stop_bad = !data_s;
`endif

  // NOTE: every next-state signal gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    key_d   = key_q;
    err_d   = 1'b0;
    timer_d = timer_q + TW'(1);

    if (state_q == S_IDLE || bit_evt) begin
      timer_d = '0;
    end

    if (bit_evt) begin
      case (state_q)
        S_IDLE: begin
          if (!data_s) begin
            state_d = S_DATA;
            count_d = 3'd0;
          end
        end
        S_DATA: begin
          shift_d = {data_s, shift_q[7:1]};
          count_d = count_q + 3'd1;
          if (count_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (stop_bad) begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else if (shift_q == PS2_PREFIX_EXT) begin
            ext_d = 1'b1;
          end else if (shift_q == PS2_PREFIX_BRK) begin
            brk_d = 1'b1;
          end else begin
            key_d = {~key_q[KEY_TOGGLE], ~brk_q, ext_q, shift_q};
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && timer_q == TIMER_LAST) begin
      // A stalled frame is abandoned along with any pending prefix.
      state_d = S_IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      count_q <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      key_q   <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      key_q   <= key_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random frames
// compared against a frame-level behavioural model of the key word.
module tb_ps2_key_decoder;

  localparam int FL = 8;
  localparam int TO = 400;
`ifdef PS2_KEY_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_data_in = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(FL)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_key     (ps2_key),
    .frame_err   (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Observation: error-cycle count, last error cycle, key word changes.
  int unsigned err_cnt = 0;
  int unsigned err_cyc = 0;
  int unsigned key_chg = 0;
  logic [10:0] prev_key = '0;
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (frame_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (ps2_key !== prev_key) key_chg++;
    end
    prev_key = ps2_key;
  end

  int unsigned pass_cnt = 0;
  int unsigned fail_cnt = 0;
  int unsigned total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: tracks prefixes and the event word at frame granularity.
  logic [10:0] m_key = '0;
  bit          m_ext = 1'b0;
  bit          m_brk = 1'b0;
  int unsigned m_err = 0;
  int unsigned m_evt = 0;

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      m_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      m_key = {~m_key[10], ~m_brk, m_ext, b};
      m_ext = 1'b0;
      m_brk = 1'b0;
      m_evt++;
    end
  endtask

  task automatic model_abort();
    m_err++;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  int unsigned last_fall = 0;

  task automatic send_bit(input logic b, input int h, input bit glitch);
    ps2_data_in = b;
    if (glitch) begin
      tick(15);
      ps2_clk_in = 1'b0;
      tick(3);
      ps2_clk_in = 1'b1;
      tick(22);
    end else begin
      tick(h);
    end
    ps2_clk_in = 1'b0;
    last_fall = cyc;
    tick(h);
    ps2_clk_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop,
                            input bit glitch);
    int h;
    logic p;
    h = int'($urandom_range(14, 30));
    p = par_ok ? ~(^b) : (^b);
    send_bit(1'b0, h, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], h, glitch && i == 3);
    send_bit(p, h, 1'b0);
    send_bit(stop, h, 1'b0);
    ps2_data_in = 1'b1;
    tick(2 * h);
    model_frame(b, stop && (par_ok || !PAR_EN));
  endtask

  task automatic send_partial(input int nbits);
    send_bit(1'b0, 20, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)), 20, 1'b0);
    ps2_data_in = 1'b1;
    tick(TO + 40);
    model_abort();
  endtask

  task automatic check_state(input string tag);
    check({tag, ".key"}, 32'(ps2_key), 32'(m_key));
    check({tag, ".err"}, err_cnt, m_err);
    check({tag, ".evt"}, key_chg, m_evt);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rb;
    int unsigned kind;
    int unsigned t_evt;

    // Reset state
    tick(5);
    check("reset.key", 32'(ps2_key), 32'h0);
    check("reset.err", 32'(frame_err), 32'h0);
    reset_n = 1'b1;
    tick(20);

    // Plain make code
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check("make_1c.key", 32'(ps2_key), 32'h61C);
    check_state("make_1c");

    // Extended break: prefixes alone must not move the word
    send_frame(8'hE0, 1'b1, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    check("prefix.nochange", key_chg, 32'd1);
    send_frame(8'h75, 1'b1, 1'b1, 1'b0);
    check("ext_brk.key", 32'(ps2_key), 32'h175);
    check_state("ext_brk");

    // Wrong (even) parity
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check_state("bad_parity");

    // Timeout after start + 3 data bits, with exact error timing
    send_bit(1'b0, 20, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 20, 1'b0);
    t_evt = last_fall;
    ps2_data_in = 1'b1;
    tick(TO + 40);
    model_abort();
    check("timeout.cycle", err_cyc, t_evt + FL + 4 + TO);
    check_state("timeout");
    send_frame(8'h29, 1'b1, 1'b1, 1'b0);
    check_state("after_timeout");

    // Clock glitch inside the data bits
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
    check_state("glitch");

    // Stop bit low
    send_frame(8'h33, 1'b1, 1'b0, 1'b0);
    check_state("bad_stop");

    // Reset in the middle of a frame following an E0 prefix
    send_frame(8'hE0, 1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 20, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 20, 1'b0);
    ps2_clk_in = 1'b0;
    tick(4);
    reset_n = 1'b0;
    tick(3);
    ps2_clk_in = 1'b1;
    ps2_data_in = 1'b1;
    m_key = '0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    check("midreset.key", 32'(ps2_key), 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(30);
    send_frame(8'h75, 1'b1, 1'b1, 1'b0);
    check("midreset.after", 32'(ps2_key), 32'h675);
    check_state("midreset");

    // Random traffic
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 9);
      rb = 8'($urandom);
      case (kind)
        0: send_frame(rb, 1'b1, 1'b0, 1'b0);
        1: send_frame(rb, 1'b0, 1'b1, 1'b0);
        2: send_partial(int'($urandom_range(0, 7)));
        3: send_frame(8'hE0, 1'b1, 1'b1, 1'b0);
        4: send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        default: send_frame(rb, 1'b1, 1'b1, kind == 9);
      endcase
      check_state($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
